elevator_call_latch: RTL and testbench
======================================

# elevator_call_latch

Upstream request stage for the three-floor elevator controller. Captures momentary hall buttons (u1, u2, d2, d3) and car buttons (f1, f2, f3), holds each as a pending call until the controller serves it, and presents pending-call lamps plus above/here/below summaries relative to the car's current floor. Clearing is driven by the controller's own door/dir outputs and the floor sensor.

## Interface
- DEBOUNCE_CYCLES, 3: consecutive high samples required before a press registers (used only with debounce compiled in)
- clk  in  1  system clock; all inputs synchronous to it
- rst  in  1  asynchronous, active-high reset
- u1, u2, d2, d3  in  1 each  hall call buttons, 1 = pressed
- f1, f2, f3  in  1 each  car call buttons, 1 = pressed
- fs  in  2  floor sensor: 01/10/11 = floor 1/2/3, 00 = between floors
- door  in  1  controller door output, 1 = closed, 0 = open
- dir  in  2  controller direction: 00 idle, 01 up, 10 down
- pend  out  7  pending calls, bit order {f3,f2,f1,d3,d2,u2,u1} (bit 0 = u1)
- req_here  out  1  any pending call at cur_floor
- req_above  out  1  any pending call at a floor above cur_floor
- req_below  out  1  any pending call at a floor below cur_floor

## Operation
- cur_floor register: loads fs whenever fs != 00; holds otherwise. Reset 01.
- last_dir register: loads dir whenever dir != 00; holds otherwise. Reset 00.
- Set: each button produces a one-cycle set strobe on its registered press; strobe sets the matching pend bit. Holding a button produces one strobe only; re-arm requires the input to go low.
- Clear (evaluated every cycle with door == 0 and fs != 00; floor N = fs):
  - fN always cleared.
  - Floor 1: u1 cleared. Floor 3: d3 cleared.
  - Floor 2: last_dir 01 → clear u2; last_dir 10 → clear d2; last_dir 00 → clear both.
  - Floor 2 turn-around: last_dir 01 and no pending f3/d3 → also clear d2; last_dir 10 and no pending f1/u1 → also clear u2.
- Set and clear on the same bit in the same cycle: clear wins.
- Summaries are combinational from pend and cur_floor; no pend bit at a floor contributes to more than one of here/above/below.
- Reset mid-operation: all pend bits, debounce counters, cur_floor, last_dir return to reset values immediately; strobes suppressed until rst deasserts and inputs re-qualify.

## Timing
- Reset values: pend = 0000000, req_here = req_above = req_below = 0.
- Press-to-lamp latency: debounce compiled in, pend bit rises on the clock edge at which the input has been sampled high DEBOUNCE_CYCLES consecutive edges; compiled out, one edge after first high sample.
- Clear latency: pend bit falls on the first clk edge where door == 0 and fs matches; summaries follow in the same cycle.
- Summaries update combinationally with pend/cur_floor changes; no additional register stage.
- Debounce counter: saturating, width $clog2(DEBOUNCE_CYCLES+1), zeroed whenever input samples low.

## Configuration
- ELEVATOR_CALL_DEBOUNCE_EN defined: each button passes through a counter; a press shorter than DEBOUNCE_CYCLES edges is discarded.
- Undefined: counters removed; strobe = input high now and low in the previous cycle (one register per button); DEBOUNCE_CYCLES ignored.

## Structure
- elevator_pkg: floor encodings (FLOOR1 = 01, FLOOR2 = 10, FLOOR3 = 11, FLOOR_NONE = 00), dir encodings (DIR_IDLE, DIR_UP, DIR_DOWN), pend bit index constants.
- Sub-module call_debounce: one per button (seven instances), input raw level, output one-cycle set strobe; contains the macro-dependent logic.

## Test plan
- Reset with fs = 01, door = 1, dir = 00 → pend = 0, all req_* = 0; release rst, idle 10 cycles → unchanged.
- Debounce on, DEBOUNCE_CYCLES = 3: f2 high 2 cycles → pend stays 0; f2 high 5 cycles → pend[5] = 1 after third edge, req_above = 1, single set despite hold.
- fs = 01, pend f3 set; dir = 01 then fs = 10, door = 0 → f3 stays set, req_above = 1, req_here = 0.
- last_dir = 01, pend u2 and d2 set, no f3/d3; fs = 10, door = 0 → both u2 and d2 clear same edge.
- last_dir = 10, pend d2, u2, u1 set; arrive fs = 10, door = 0 → d2 clears, u2 and u1 stay, req_below = 1.
- fs = 10, door = 0, press f2 → pend[5] never observed high; assert rst mid-travel with pend = 1010101 → pend = 0 on next sample, cur_floor = 01.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared encodings for the elevator call latch: floor and direction codes,
// and the bit positions of each call inside the pending-call vector.
package elevator_pkg;

    typedef enum logic [1:0] {
        FLOOR_NONE = 2'b00,
        FLOOR1     = 2'b01,
        FLOOR2     = 2'b10,
        FLOOR3     = 2'b11
    } floor_t;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_t;

    localparam int NUM_CALLS = 7;
    localparam int P_U1 = 0;
    localparam int P_U2 = 1;
    localparam int P_D2 = 2;
    localparam int P_D3 = 3;
    localparam int P_F1 = 4;
    localparam int P_F2 = 5;
    localparam int P_F3 = 6;

    // Calls belonging to each floor, used to build the here/above/below summaries.
    localparam logic [NUM_CALLS-1:0] AT_FLOOR1 = 7'b0010001;
    localparam logic [NUM_CALLS-1:0] AT_FLOOR2 = 7'b0100110;
    localparam logic [NUM_CALLS-1:0] AT_FLOOR3 = 7'b1001000;

endpackage

// File: rtl/call_debounce.sv
// Turns one raw button level into a single-cycle set strobe per press.
// ELEVATOR_CALL_DEBOUNCE_EN selects the counter-qualified variant.
module call_debounce
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic strobe
);

`ifdef ELEVATOR_CALL_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!raw) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Fires on the edge that completes the run; saturation keeps a held button quiet.
    assign strobe = raw && (cnt == CNT_LAST) && !rst;
`else
    logic prev;
    logic unused_cfg;

    assign unused_cfg = (DEBOUNCE_CYCLES > 0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= 1'b0;
        end else begin
            prev <= raw;
        end
    end

    assign strobe = raw && !prev && !rst;
`endif

endmodule

// File: rtl/elevator_call_latch.sv
// Pending-call latch for a three-floor elevator: hall/car buttons set lamps,
// arrival with the door open clears them. Optional debounce: ELEVATOR_CALL_DEBOUNCE_EN.
module elevator_call_latch
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       u1,
    input  logic       u2,
    input  logic       d2,
    input  logic       d3,
    input  logic       f1,
    input  logic       f2,
    input  logic       f3,
    input  logic [1:0] fs,
    input  logic       door,
    input  logic [1:0] dir,
    output logic [6:0] pend,
    output logic       req_here,
    output logic       req_above,
    output logic       req_below
);

    logic [NUM_CALLS-1:0] raw;
    logic [NUM_CALLS-1:0] strobe;
    logic [NUM_CALLS-1:0] clr;
    floor_t               cur_floor;
    dir_t                 last_dir;
    logic                 at1, at2, at3;

    assign raw = {f3, f2, f1, d3, d2, u2, u1};

    for (genvar i = 0; i < NUM_CALLS; i++) begin : g_btn
        call_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk   (clk),
            .rst   (rst),
            .raw   (raw[i]),
            .strobe(strobe[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_floor <= FLOOR1;
            last_dir  <= DIR_IDLE;
        end else begin
            if (fs != FLOOR_NONE) cur_floor <= floor_t'(fs);
            if (dir != DIR_IDLE)  last_dir  <= dir_t'(dir);
        end
    end

    // A floor-2 hall call is served when the car travels its way, is idle,
    // or is about to turn around because nothing is pending further on.
    always_comb begin
        clr = '0;
        if (!door && fs != FLOOR_NONE) begin
            case (floor_t'(fs))
                FLOOR1: begin
                    clr[P_F1] = 1'b1;
                    clr[P_U1] = 1'b1;
                end
                FLOOR2: begin
                    clr[P_F2] = 1'b1;
                    case (last_dir)
                        DIR_IDLE: begin
                            clr[P_U2] = 1'b1;
                            clr[P_D2] = 1'b1;
                        end
                        DIR_UP: begin
                            clr[P_U2] = 1'b1;
                            if (!pend[P_F3] && !pend[P_D3]) clr[P_D2] = 1'b1;
                        end
                        DIR_DOWN: begin
                            clr[P_D2] = 1'b1;
                            if (!pend[P_F1] && !pend[P_U1]) clr[P_U2] = 1'b1;
                        end
                        default: ;
                    endcase
                end
                FLOOR3: begin
                    clr[P_F3] = 1'b1;
                    clr[P_D3] = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= (pend | strobe) & ~clr;
        end
    end

    assign at1 = |(pend & AT_FLOOR1);
    assign at2 = |(pend & AT_FLOOR2);
    assign at3 = |(pend & AT_FLOOR3);

    always_comb begin
        req_here  = 1'b0;
        req_above = 1'b0;
        req_below = 1'b0;
        case (cur_floor)
            FLOOR1: begin
                req_here  = at1;
                req_above = at2 | at3;
            end
            FLOOR2: begin
                req_here  = at2;
                req_above = at3;
                req_below = at1;
            end
            FLOOR3: begin
                req_here  = at3;
                req_below = at1 | at2;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_elevator_call_latch.sv
// Self-checking bench for elevator_call_latch: directed scenarios plus a
// randomized run against a floor-level behavioural model of call service.
module tb_elevator_call_latch;

`ifdef ELEVATOR_CALL_DEBOUNCE_EN
    localparam int QUAL = 3;
`else
    localparam int QUAL = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] btn = '0;
    logic [1:0] fs = 2'b01;
    logic       door = 1'b1;
    logic [1:0] dir = 2'b00;
    logic [6:0] pend;
    logic       req_here, req_above, req_below;

    int n_checks = 0;
    int n_pass = 0;

    // Reference model state
    int         run [7];
    logic [6:0] m_pend = '0;
    int         m_cur = 1;
    int         m_last = 0;

    elevator_call_latch #(.DEBOUNCE_CYCLES(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .u1       (btn[0]),
        .u2       (btn[1]),
        .d2       (btn[2]),
        .d3       (btn[3]),
        .f1       (btn[4]),
        .f2       (btn[5]),
        .f3       (btn[6]),
        .fs       (fs),
        .door     (door),
        .dir      (dir),
        .pend     (pend),
        .req_here (req_here),
        .req_above(req_above),
        .req_below(req_below)
    );

    always #5 clk = ~clk;

    function automatic int bfloor(input int i);
        int fl [7] = '{1, 2, 2, 3, 1, 2, 3};
        return fl[i];
    endfunction

    // {here, above, below} from the floor each pending call belongs to
    function automatic logic [2:0] exp_sum(input logic [6:0] p, input int cur);
        logic [2:0] r = 3'b000;
        for (int i = 0; i < 7; i++) begin
            if (p[i]) begin
                if (bfloor(i) == cur)     r[2] = 1'b1;
                else if (bfloor(i) > cur) r[1] = 1'b1;
                else                      r[0] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic model_edge();
        logic [6:0] set_v = '0;
        logic [6:0] clr_v = '0;
        int fl;
        if (rst) begin
            for (int i = 0; i < 7; i++) run[i] = 0;
            m_pend = '0;
            m_cur = 1;
            m_last = 0;
            return;
        end
        for (int i = 0; i < 7; i++) begin
            if (btn[i]) begin
                if (run[i] < 1000) run[i]++;
            end else begin
                run[i] = 0;
            end
            if (run[i] == QUAL) set_v[i] = 1'b1;
        end
        if (!door && fs != 2'b00) begin
            fl = int'(fs);
            for (int i = 0; i < 7; i++) begin
                if (bfloor(i) == fl) begin
                    if (i >= 4 || i == 0 || i == 3) clr_v[i] = 1'b1;
                    else if (i == 1)
                        clr_v[i] = (m_last == 0 || m_last == 1 ||
                                    (m_last == 2 && !m_pend[0] && !m_pend[4]));
                    else
                        clr_v[i] = (m_last == 0 || m_last == 2 ||
                                    (m_last == 1 && !m_pend[3] && !m_pend[6]));
                end
            end
        end
        m_pend = (m_pend | set_v) & ~clr_v;
        if (fs != 2'b00) m_cur = int'(fs);
        if (dir != 2'b00) m_last = int'(dir);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic reset_dut();
        btn = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic press(input logic [6:0] mask, input int cycles);
        btn = btn | mask;
        repeat (cycles) step();
        btn = btn & ~mask;
        step();
    endtask

    task automatic test_reset();
        fs = 2'b01; door = 1'b1; dir = 2'b00;
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if (pend !== 7'b0) $display("FAIL reset_pend got=%b exp=%b", pend, 7'b0);
        else n_pass++;
        n_checks++;
        if ({req_here, req_above, req_below} !== 3'b000)
            $display("FAIL reset_req got=%b exp=%b", {req_here, req_above, req_below}, 3'b000);
        else n_pass++;
        rst = 1'b0;
        repeat (10) step();
        n_checks++;
        if (pend !== 7'b0) $display("FAIL idle_pend got=%b exp=%b", pend, 7'b0);
        else n_pass++;
        n_checks++;
        if ({req_here, req_above, req_below} !== 3'b000)
            $display("FAIL idle_req got=%b exp=%b", {req_here, req_above, req_below}, 3'b000);
        else n_pass++;
    endtask

    task automatic test_debounce();
        logic [6:0] exp_short;
        reset_dut();
        fs = 2'b01; door = 1'b1; dir = 2'b00;
`ifdef ELEVATOR_CALL_DEBOUNCE_EN
        exp_short = 7'b0000000;
`else
        exp_short = 7'b0100000;
`endif
        press(7'b0100000, 2);
        n_checks++;
        if (pend !== exp_short) $display("FAIL short_press got=%b exp=%b", pend, exp_short);
        else n_pass++;
        fs = 2'b10; door = 1'b0; step();
        fs = 2'b01; door = 1'b1; step();
        n_checks++;
        if (pend !== 7'b0) $display("FAIL short_cleanup got=%b exp=%b", pend, 7'b0);
        else n_pass++;
        btn[5] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            n_checks++;
            if (pend[5] !== (k >= QUAL)) $display("FAIL hold_edge%0d got=%b exp=%b", k, pend[5], (k >= QUAL));
            else n_pass++;
            if (k == QUAL) begin
                n_checks++;
                if (req_above !== 1'b1) $display("FAIL hold_above got=%b exp=1", req_above);
                else n_pass++;
            end
        end
        fs = 2'b10; door = 1'b0; step();
        door = 1'b1; step(); step();
        n_checks++;
        if (pend !== 7'b0) $display("FAIL single_set got=%b exp=%b", pend, 7'b0);
        else n_pass++;
        btn[5] = 1'b0; step();
    endtask

    task automatic test_pass_through();
        reset_dut();
        fs = 2'b01; door = 1'b1; dir = 2'b00;
        press(7'b1000000, QUAL);
        dir = 2'b01; step();
        fs = 2'b10; door = 1'b0; step();
        n_checks++;
        if (pend !== 7'b1000000) $display("FAIL pass_f3 got=%b exp=%b", pend, 7'b1000000);
        else n_pass++;
        n_checks++;
        if ({req_here, req_above} !== 2'b01)
            $display("FAIL pass_req got=%b exp=%b", {req_here, req_above}, 2'b01);
        else n_pass++;
        door = 1'b1; dir = 2'b00;
    endtask

    task automatic test_turnaround();
        reset_dut();
        fs = 2'b01; door = 1'b1; dir = 2'b01; step();
        dir = 2'b00;
        press(7'b0000110, QUAL);
        n_checks++;
        if (pend !== 7'b0000110) $display("FAIL turn_setup got=%b exp=%b", pend, 7'b0000110);
        else n_pass++;
        fs = 2'b10; door = 1'b0; step();
        n_checks++;
        if (pend !== 7'b0) $display("FAIL turn_clear got=%b exp=%b", pend, 7'b0);
        else n_pass++;
        door = 1'b1;
    endtask

    task automatic test_down_arrival();
        reset_dut();
        fs = 2'b11; door = 1'b1; step();
        dir = 2'b10; step();
        dir = 2'b00;
        press(7'b0000111, QUAL);
        n_checks++;
        if (pend !== 7'b0000111) $display("FAIL down_setup got=%b exp=%b", pend, 7'b0000111);
        else n_pass++;
        fs = 2'b10; door = 1'b0; step();
        n_checks++;
        if (pend !== 7'b0000011) $display("FAIL down_clear got=%b exp=%b", pend, 7'b0000011);
        else n_pass++;
        n_checks++;
        if ({req_here, req_above, req_below} !== 3'b101)
            $display("FAIL down_req got=%b exp=%b", {req_here, req_above, req_below}, 3'b101);
        else n_pass++;
        door = 1'b1;
    endtask

    task automatic test_clear_wins();
        reset_dut();
        fs = 2'b10; door = 1'b0; step();
        btn[5] = 1'b1;
        for (int k = 0; k < QUAL + 2; k++) begin
            step();
            n_checks++;
            if (pend[5] !== 1'b0) $display("FAIL clear_wins%0d got=%b exp=0", k, pend[5]);
            else n_pass++;
        end
        btn[5] = 1'b0; step();
        door = 1'b1;
    endtask

    task automatic test_reset_mid();
        reset_dut();
        fs = 2'b11; door = 1'b1; step();
        fs = 2'b00;
        press(7'b1010101, QUAL);
        n_checks++;
        if (pend !== 7'b1010101) $display("FAIL mid_setup got=%b exp=%b", pend, 7'b1010101);
        else n_pass++;
        n_checks++;
        if ({req_here, req_above, req_below} !== 3'b101)
            $display("FAIL mid_req got=%b exp=%b", {req_here, req_above, req_below}, 3'b101);
        else n_pass++;
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (pend !== 7'b0) $display("FAIL mid_rst_pend got=%b exp=%b", pend, 7'b0);
        else n_pass++;
        n_checks++;
        if ({req_here, req_above, req_below} !== 3'b000)
            $display("FAIL mid_rst_req got=%b exp=%b", {req_here, req_above, req_below}, 3'b000);
        else n_pass++;
        step();
        rst = 1'b0;
        press(7'b0100000, QUAL);
        n_checks++;
        if ({req_here, req_above, req_below} !== 3'b010)
            $display("FAIL mid_cur_floor got=%b exp=%b", {req_here, req_above, req_below}, 3'b010);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [2:0] es;
        reset_dut();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 7; i++)
                if ($urandom_range(0, 3) == 0) btn[i] = ~btn[i];
            if ($urandom_range(0, 3) == 0) fs = 2'($urandom_range(0, 3));
            door = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 7) == 0) dir = 2'($urandom_range(0, 2));
            rst = ($urandom_range(0, 99) == 0);
            step();
            es = exp_sum(m_pend, m_cur);
            n_checks++;
            if (pend !== m_pend) $display("FAIL rand_pend cyc=%0d got=%b exp=%b", c, pend, m_pend);
            else n_pass++;
            n_checks++;
            if ({req_here, req_above, req_below} !== es)
                $display("FAIL rand_req cyc=%0d got=%b exp=%b", c, {req_here, req_above, req_below}, es);
            else n_pass++;
        end
        rst = 1'b0;
        btn = '0;
    endtask

    initial begin
        for (int i = 0; i < 7; i++) run[i] = 0;
        test_reset();
        test_debounce();
        test_pass_through();
        test_turnaround();
        test_down_arrival();
        test_clear_wins();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
